sprite_list_buffer: RTL
=======================

Name: sprite_list_buffer

Overview:
- Downstream consumer of the game processor's per-frame sprite stream (x, y, frame, sprite_valid).
- Collects every sprite emitted during one game tick into a write bank. At new_frame it publishes that bank to the pixel renderer through a double buffer.
- The renderer reads sprite descriptors by index with one-cycle latency, while the processor fills the other bank.

Parameters:
- CANVAS_WIDTH, 100, horizontal extent; XW = $clog2(CANVAS_WIDTH)
- CANVAS_HEIGHT, 100, vertical extent; YW = $clog2(CANVAS_HEIGHT)
- NUM_FRAMES, 100, animation frame count; FW = $clog2(NUM_FRAMES)
- MAX_SPRITES, 16, entries per bank; IW = $clog2(MAX_SPRITES), CW = $clog2(MAX_SPRITES+1)

Ports:
- pixel_clk_in  in  1  sole clock
- rst_in  in  1  reset, asynchronous, active-low
- new_frame  in  1  frame-boundary pulse from the processor
- sprite_valid  in  1  sprite descriptor present this cycle
- x  in  XW  sprite x
- y  in  YW  sprite y
- frame  in  FW  sprite animation frame
- render_busy  in  1  renderer is scanning the published bank; a swap is not permitted
- rd_en  in  1  read request
- rd_idx  in  IW  entry index in the published bank
- rd_valid  out  1  rd_* data valid; asserted 1 cycle after rd_en
- rd_x  out  XW  published sprite x
- rd_y  out  YW  published sprite y
- rd_frame  out  FW  published sprite animation frame
- sprite_count  out  CW  number of valid entries in the published bank
- overflow  out  1  published frame dropped at least one sprite
- swap_pulse  out  1  one-cycle strobe: a new bank was published

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=FILL, wr_bank=0, wr_ptr=0, ovf_acc=0, ovf_next=0.
  - All outputs 0, including rd_*, sprite_count, overflow, swap_pulse.
  - Bank contents are don't-care; sprite_count=0 makes them unreadable.
  - Asserting reset mid-fill or mid-pending discards everything.
- FSM states: FILL, PENDING.
- FILL, sprite_valid=1 and new_frame=0:
  - If wr_ptr<MAX_SPRITES: write {x,y,frame} to wr_bank[wr_ptr], wr_ptr++.
  - Else: drop the sprite and set ovf_acc=1.
- FILL, new_frame=1 and render_busy=0 (swap):
  - pub_bank<=wr_bank; wr_bank flips.
  - sprite_count<=wr_ptr; overflow<=ovf_acc; swap_pulse=1 on the next cycle only.
  - ovf_acc<=0.
  - A sprite_valid in the same cycle belongs to the new frame: it is written to entry 0 of the new write bank, and wr_ptr<=1 (else wr_ptr<=0).
- FILL, new_frame=1 and render_busy=1:
  - Go to PENDING. The current bank is frozen as is; the same-cycle sprite is treated as a PENDING sprite.
- PENDING:
  - sprite_valid sprites are dropped, and each sets ovf_next=1.
  - Further new_frame pulses are ignored (frame merged; no extra swap).
- PENDING exit, first cycle with render_busy=0:
  - Perform the swap (as above) with wr_ptr<=0 and ovf_acc<=ovf_next, then ovf_next<=0.
  - Return to FILL.
  - A sprite arriving in that exit cycle is dropped and sets ovf_acc=1.
- Read path:
  - rd_en and rd_idx are sampled at the clock edge against the pre-edge pub_bank and sprite_count.
  - If rd_idx<sprite_count: rd_valid=1 next cycle with that entry's data.
  - Otherwise: rd_valid=0 and rd_*=0.
  - rd_valid=0 whenever rd_en was 0.
- Throughput:
  - Back-to-back reads are allowed, one per cycle.
  - Writes and reads never target the same bank.
- No combinational path from any input to any output.

Decomposition:
- Package sprite_pkg:
  - sprite_t packed struct {x[XW], y[YW], frame[FW]}.
  - Width localparams derived from the canvas and frame parameters.
  - fill_state_t enum {FILL, PENDING}.
- Sub-module sprite_bank: MAX_SPRITES×sprite_t register array with one write port and a registered read port.
- Instantiated twice, selected by wr_bank/pub_bank.

Test Plan:
- Write 3 sprites (10,20,1),(30,40,2),(50,60,3), then new_frame with render_busy=0:
  - swap_pulse pulses once; sprite_count=3; overflow=0.
  - Reads of idx 0..2 return those sprites with rd_valid one cycle later.
- MAX_SPRITES=16, write 18 sprites, then new_frame → sprite_count=16, overflow=1. The next clean frame reports overflow=0.
- new_frame and sprite_valid (7,8,9) in the same cycle, followed by a second new_frame → the second publish has sprite_count=1 and idx0=(7,8,9).
- Hold render_busy=1 across new_frame:
  - Send 2 sprites and another new_frame → no swap_pulse, published data unchanged.
  - Drop render_busy → swap_pulse; the next publish reports overflow=1.
- rd_en with rd_idx=5 while sprite_count=3 → rd_valid=0, rd_x=rd_y=rd_frame=0.
- Pull rst_in low mid-fill after 4 sprites and release → sprite_count=0, swap_pulse=0. The next frame with 1 sprite publishes sprite_count=1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared widths, sprite descriptor layout and fill-FSM states for the sprite list buffer.
package sprite_pkg;
   localparam int CANVAS_WIDTH  = 100;
   localparam int CANVAS_HEIGHT = 100;
   localparam int NUM_FRAMES    = 100;
   localparam int MAX_SPRITES   = 16;

   localparam int XW = $clog2(CANVAS_WIDTH);
   localparam int YW = $clog2(CANVAS_HEIGHT);
   localparam int FW = $clog2(NUM_FRAMES);
   localparam int IW = $clog2(MAX_SPRITES);
   localparam int CW = $clog2(MAX_SPRITES + 1);

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [FW-1:0] frame;
   } sprite_t;

   typedef enum logic {
      FILL    = 1'b0,
      PENDING = 1'b1
   } fill_state_t;
endpackage

// File: rtl/sprite_list_buffer_if.sv
// Sprite stream, renderer read port and publish status between processor, buffer and renderer.
interface sprite_list_buffer_if;
   import sprite_pkg::*;

   logic          new_frame;
   logic          sprite_valid;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [FW-1:0] frame;
   logic          render_busy;
   logic          rd_en;
   logic [IW-1:0] rd_idx;
   logic          rd_valid;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [FW-1:0] rd_frame;
   logic [CW-1:0] sprite_count;
   logic          overflow;
   logic          swap_pulse;

   modport master (
      output new_frame, sprite_valid, x, y, frame, render_busy, rd_en, rd_idx,
      input  rd_valid, rd_x, rd_y, rd_frame, sprite_count, overflow, swap_pulse
   );

   modport slave (
      input  new_frame, sprite_valid, x, y, frame, render_busy, rd_en, rd_idx,
      output rd_valid, rd_x, rd_y, rd_frame, sprite_count, overflow, swap_pulse
   );
endinterface

// File: rtl/sprite_bank.sv
// One bank of sprite descriptors: single write port, registered read port, no reset on storage.
module sprite_bank
   import sprite_pkg::*;
(
   input  logic          clk,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_addr,
   input  sprite_t       wr_data,
   input  logic          rd_en,
   input  logic [IW-1:0] rd_addr,
   output sprite_t       rd_data
);
   sprite_t mem [MAX_SPRITES];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/sprite_list_buffer.sv
// Double-buffered per-frame sprite list: processor fills one bank while the renderer reads the other.
//
// state   | meaning
// FILL    | accepting sprites into wr_bank; new_frame swaps unless renderer is busy
// PENDING | swap requested while renderer busy; sprites dropped until busy clears
module sprite_list_buffer
   import sprite_pkg::*;
(
   input  logic               pixel_clk_in,
   input  logic               rst_in,
   sprite_list_buffer_if.slave bus
);
   fill_state_t   state;
   logic          wr_bank;
   logic          pub_bank;
   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] sprite_count;
   logic          ovf_acc;
   logic          ovf_next;
   logic          overflow;
   logic          swap_pulse;
   logic          rd_valid_q;
   logic          rd_sel;

   logic          wr_en;
   logic          wr_tgt;
   logic [IW-1:0] wr_addr;
   sprite_t       wr_data;
   sprite_t       rd_data0;
   sprite_t       rd_data1;
   sprite_t       rd_data;
   logic          rd_hit;

   assign wr_data = {bus.x, bus.y, bus.frame};
   assign rd_hit  = bus.rd_en && ({1'b0, bus.rd_idx} < sprite_count);

   // A sprite coincident with a clean swap belongs to the new frame, so it lands in the other bank.
   always_comb begin
      wr_en   = 1'b0;
      wr_tgt  = wr_bank;
      wr_addr = wr_ptr[IW-1:0];
      if (state == FILL && bus.sprite_valid) begin
         if (bus.new_frame && !bus.render_busy) begin
            wr_en   = 1'b1;
            wr_tgt  = ~wr_bank;
            wr_addr = '0;
         end else if (!bus.new_frame && wr_ptr < CW'(MAX_SPRITES)) begin
            wr_en = 1'b1;
         end
      end
   end

   sprite_bank u_bank0 (
      .clk     (pixel_clk_in),
      .wr_en   (wr_en && !wr_tgt),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (bus.rd_en),
      .rd_addr (bus.rd_idx),
      .rd_data (rd_data0)
   );

   sprite_bank u_bank1 (
      .clk     (pixel_clk_in),
      .wr_en   (wr_en && wr_tgt),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (bus.rd_en),
      .rd_addr (bus.rd_idx),
      .rd_data (rd_data1)
   );

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= FILL;
         wr_bank      <= 1'b0;
         pub_bank     <= 1'b0;
         wr_ptr       <= '0;
         sprite_count <= '0;
         ovf_acc      <= 1'b0;
         ovf_next     <= 1'b0;
         overflow     <= 1'b0;
         swap_pulse   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_sel       <= 1'b0;
      end else begin
         swap_pulse <= 1'b0;
         rd_valid_q <= rd_hit;
         rd_sel     <= pub_bank;
         case (state)
            FILL: begin
               if (bus.new_frame && !bus.render_busy) begin
                  pub_bank     <= wr_bank;
                  wr_bank      <= ~wr_bank;
                  sprite_count <= wr_ptr;
                  overflow     <= ovf_acc;
                  swap_pulse   <= 1'b1;
                  ovf_acc      <= 1'b0;
                  wr_ptr       <= bus.sprite_valid ? CW'(1) : '0;
               end else if (bus.new_frame) begin
                  state <= PENDING;
                  if (bus.sprite_valid) ovf_next <= 1'b1;
               end else if (bus.sprite_valid) begin
                  if (wr_ptr < CW'(MAX_SPRITES)) wr_ptr <= wr_ptr + CW'(1);
                  else                           ovf_acc <= 1'b1;
               end
            end
            PENDING: begin
               if (!bus.render_busy) begin
                  pub_bank     <= wr_bank;
                  wr_bank      <= ~wr_bank;
                  sprite_count <= wr_ptr;
                  overflow     <= ovf_acc;
                  swap_pulse   <= 1'b1;
                  wr_ptr       <= '0;
                  ovf_acc      <= ovf_next | bus.sprite_valid;
                  ovf_next     <= 1'b0;
                  state        <= FILL;
               end else if (bus.sprite_valid) begin
                  ovf_next <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign rd_data          = rd_sel ? rd_data1 : rd_data0;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_x         = rd_valid_q ? rd_data.x     : '0;
   assign bus.rd_y         = rd_valid_q ? rd_data.y     : '0;
   assign bus.rd_frame     = rd_valid_q ? rd_data.frame : '0;
   assign bus.sprite_count = sprite_count;
   assign bus.overflow     = overflow;
   assign bus.swap_pulse   = swap_pulse;
endmodule
